// File: rtl/video_line_fetch.sv
// video_line_fetch: fetches one video line from a shadow-memory video port
// into the back half of a double-buffered line store, while a consumer reads
// the front half. A swap exchanges front and back. If a swap is requested
// during a fetch, it is deferred until that fetch completes.
//
// Ports:
//   clk_logic, system_reset_n    sole clock, synchronous active-low reset
//   line_start_i, line_base_i,   start a fetch of line_words_i 32-bit words
//   line_words_i, line_bank_i    from byte address line_base_i in bank line_bank_i
//   swap_i                       exchange front and back buffers
//   video_rd_o, video_address_o, read request to the video port
//   video_bank_o
//   video_data_i,                read data and its valid strobe
//   video_data_valid_i
//   rd_index_i, rd_data_o        consumer read of the front buffer (1-cycle latency)
//   busy_o, done_o,              fetch status; done_o pulses once per completed line
//   timeout_err_o                sticky: some request was never answered
module video_line_fetch #(
  parameter int unsigned BUF_DEPTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic          clk_logic,
  input  logic          system_reset_n,
  input  logic          line_start_i,
  input  logic [15:0]   line_base_i,
  input  logic [6:0]    line_words_i,
  input  logic          line_bank_i,
  input  logic          swap_i,
  output logic          video_rd_o,
  output logic [15:0]   video_address_o,
  output logic          video_bank_o,
  input  logic [31:0]   video_data_i,
  input  logic          video_data_valid_i,
  input  logic [IW-1:0] rd_index_i,
  output logic [31:0]   rd_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          timeout_err_o
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [15:0]     base_q, base_d;
  logic            bank_q, bank_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [IW-1:0]   wi_q, wi_d;
  logic            fill_q, fill_d;
  logic [TW-1:0]   to_q, to_d;
  logic            front_q, front_d;
  logic            pend_q, pend_d;
  logic            rd_q, rd_d;
  logic [15:0]     addr_q, addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [31:0]     rdat_q, rdat_d;

  logic [31:0]     mem0_q [BUF_DEPTH];
  logic [31:0]     mem1_q [BUF_DEPTH];

  logic            fin;
  logic            wr_en;
  logic            err_set;
  logic            tmo_hit;
  logic            resp;
  logic            start_nz;
  logic [6:0]      cnt_in;

  // Requested length, clamped to the buffer depth
  assign cnt_in   = (line_words_i > 7'(BUF_DEPTH)) ? 7'(BUF_DEPTH) : line_words_i;
  assign start_nz = (cnt_in != 7'd0);
  assign tmo_hit  = (to_q == TW'(TIMEOUT_CYCLES - 1));
  // A response is either real read data or an expired wait
  assign resp     = video_data_valid_i || tmo_hit;

  // State register
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  // Next-state and fetch bookkeeping
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    wi_d    = wi_q;
    fill_d  = fill_q;
    to_d    = to_q;
    fin     = 1'b0;
    wr_en   = 1'b0;
    err_set = 1'b0;

    // A new line may be started from any state; the last start always wins.
    // In IDLE a simultaneous swap lands first, so the fill target is the old front.
    if (line_start_i) begin
      base_d = line_base_i & 16'hFFFE;
      bank_d = line_bank_i;
      cnt_d  = cnt_in;
      wi_d   = '0;
      fill_d = (state_q == S_IDLE && swap_i) ? front_q : ~front_q;
    end

    case (state_q)
      S_IDLE: begin
        if (line_start_i) begin
          if (start_nz) state_d = S_REQ;
          else          fin     = 1'b1;
        end
      end
      S_REQ: begin
        if (line_start_i) begin
          // The old request is still outstanding. If it answers in this same
          // cycle, drop it now; otherwise wait it out in DRAIN.
          if (resp) begin
            to_d = '0;
            if (start_nz) state_d = S_REQ;
            else begin
              state_d = S_IDLE;
              fin     = 1'b1;
            end
          end else begin
            to_d    = to_q + 1'b1;
            state_d = S_DRAIN;
          end
        end else if (resp) begin
          wr_en   = 1'b1;
          err_set = ~video_data_valid_i;
          to_d    = '0;
          if (7'(wi_q) + 7'd1 < cnt_q) begin
            wi_d    = wi_q + 1'b1;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
            fin     = 1'b1;
          end
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_GAP: begin
        if (line_start_i && !start_nz) begin
          state_d = S_IDLE;
          fin     = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        // Swallow the stale answer (or its timeout) without writing or flagging
        if (resp) begin
          to_d = '0;
          if (cnt_d != 7'd0) state_d = S_REQ;
          else begin
            state_d = S_IDLE;
            fin     = 1'b1;
          end
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, buffer select and consumer read
  always_comb begin
    rd_d    = (state_d == S_REQ);
    busy_d  = (state_d != S_IDLE);
    done_d  = fin;
    addr_d  = base_d + (16'(wi_d) << 1);
    err_d   = err_q | err_set;
    front_d = front_q;
    pend_d  = pend_q;
    if (state_q == S_IDLE) begin
      front_d = front_q ^ swap_i;
    end else if (fin) begin
      // Deferred swaps (any number of them) land together with done
      front_d = front_q ^ (pend_q | swap_i);
      pend_d  = 1'b0;
    end else begin
      pend_d  = pend_q | swap_i;
    end
    rdat_d  = front_q ? mem1_q[rd_index_i] : mem0_q[rd_index_i];
  end

  // Datapath registers
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      base_q  <= '0;
      bank_q  <= 1'b0;
      cnt_q   <= '0;
      wi_q    <= '0;
      fill_q  <= 1'b0;
      to_q    <= '0;
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      base_q  <= base_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      wi_q    <= wi_d;
      fill_q  <= fill_d;
      to_q    <= to_d;
      front_q <= front_d;
      pend_q  <= pend_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  // Line buffers; a timed-out word is stored as zero
  always_ff @(posedge clk_logic) begin
    if (wr_en && system_reset_n) begin
      if (fill_q) mem1_q[wi_q] <= video_data_valid_i ? video_data_i : 32'h0;
      else        mem0_q[wi_q] <= video_data_valid_i ? video_data_i : 32'h0;
    end
  end

  assign video_rd_o      = rd_q;
  assign video_address_o = addr_q;
  assign video_bank_o    = bank_q;
  assign rd_data_o       = rdat_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign timeout_err_o   = err_q;

endmodule

// File: tb/tb_video_line_fetch.sv
// Bench for video_line_fetch. Stimulus queues the expected requests
// (cycle, address, bank), done pulses (cycle) and consumer reads (cycle, data).
// A negedge monitor checks every DUT output event against those queues.
module tb_video_line_fetch;

  localparam int unsigned BD = 32;
  localparam int unsigned TO = 64;
  localparam int unsigned IW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          line_start;
  logic [15:0]   line_base;
  logic [6:0]    line_words;
  logic          line_bank;
  logic          swap;
  logic [31:0]   vdata = 32'h0;
  logic          vvalid = 1'b0;
  logic [IW-1:0] idx;
  logic          video_rd;
  logic [15:0]   video_addr;
  logic          video_bank;
  logic [31:0]   rd_data;
  logic          busy;
  logic          done;
  logic          terr;

  video_line_fetch #(.BUF_DEPTH(BD), .TIMEOUT_CYCLES(TO)) dut (
    .clk_logic          (clk),
    .system_reset_n     (rst_n),
    .line_start_i       (line_start),
    .line_base_i        (line_base),
    .line_words_i       (line_words),
    .line_bank_i        (line_bank),
    .swap_i             (swap),
    .video_rd_o         (video_rd),
    .video_address_o    (video_addr),
    .video_bank_o       (video_bank),
    .video_data_i       (vdata),
    .video_data_valid_i (vvalid),
    .rd_index_i         (idx),
    .rd_data_o          (rd_data),
    .busy_o             (busy),
    .done_o             (done),
    .timeout_err_o      (terr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {int c; logic [15:0] addr; logic bank;} req_t;
  typedef struct {int c; logic [31:0] d;} dat_t;

  req_t req_q[$];
  int   done_q[$];
  dat_t rdat_q[$];
  dat_t man_q[$];

  bit          resp_en = 1'b0;
  int          resp_cyc = -1;
  logic [15:0] resp_addr = 16'h0;
  logic        rd_prev = 1'b0;

  function automatic logic [31:0] mkdata(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: request starts, done pulses and consumer reads
  always @(negedge clk) begin
    if (rst_n && video_rd && !rd_prev) begin
      if (req_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_req: got addr %h at cycle %0d, expected none", video_addr, cyc);
      end else begin
        req_t r;
        r = req_q.pop_front();
        chk("req_addr", 32'(video_addr), 32'(r.addr));
        chk("req_bank", 32'(video_bank), 32'(r.bank));
        chk("req_cycle", cyc, r.c);
      end
      if (resp_en) begin
        resp_cyc  = cyc + 2;
        resp_addr = video_addr;
      end
    end
    rd_prev = video_rd;
    if (rst_n && done) begin
      if (done_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
      end
    end
    if (rdat_q.size() != 0 && rdat_q[0].c == cyc) begin
      dat_t e;
      e = rdat_q.pop_front();
      chk("rd_data", rd_data, e.d);
    end
  end

  // Memory-side responder: auto answer 2 cycles after a request, or scheduled words
  always begin
    @(posedge clk);
    #1;
    vvalid = 1'b0;
    vdata  = 32'h0;
    if (resp_cyc == cyc) begin
      vvalid   = 1'b1;
      vdata    = mkdata(resp_addr);
      resp_cyc = -1;
    end else if (man_q.size() != 0 && man_q[0].c == cyc) begin
      dat_t m;
      m      = man_q.pop_front();
      vvalid = 1'b1;
      vdata  = m.d;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [15:0] b, input logic [6:0] w, input logic bk);
    line_start = 1'b1;
    line_base  = b;
    line_words = w;
    line_bank  = bk;
    tick(1);
    line_start = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick(1);
    swap = 1'b0;
  endtask

  task automatic read_check(input logic [IW-1:0] i, input logic [31:0] exp);
    idx = i;
    rdat_q.push_back('{cyc + 1, exp});
    tick(1);
  endtask

  task automatic drained(input string name);
    chk(name, 32'(req_q.size() + done_q.size() + rdat_q.size()), 32'd0);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; line_start = 1'b0; line_base = '0; line_words = '0;
    line_bank = 1'b0; swap = 1'b0; idx = '0;
    tick(3);
    chk("rst_rd", 32'(video_rd), 32'd0);
    chk("rst_addr", 32'(video_addr), 32'd0);
    chk("rst_bank", 32'(video_bank), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(terr), 32'd0);
    chk("rst_rdata", rd_data, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 3 words from 2000, answers 2 cycles after each request; fills buffer 1
    resp_en = 1'b1;
    c0 = cyc;
    req_q.push_back('{c0 + 1, 16'h2000, 1'b1});
    req_q.push_back('{c0 + 5, 16'h2002, 1'b1});
    req_q.push_back('{c0 + 9, 16'h2004, 1'b1});
    done_q.push_back(c0 + 12);
    start_line(16'h2001, 7'd3, 1'b1);
    chk("busy_in_fetch", 32'(busy), 32'd1);
    tick(14);
    drained("s1_drained");
    chk("s1_no_err", 32'(terr), 32'd0);
    do_swap();
    read_check(5'd1, mkdata(16'h2002));
    read_check(5'd0, mkdata(16'h2000));
    read_check(5'd2, mkdata(16'h2004));
    tick(1);

    // Address wrap FFFC, FFFE, 0000; fills buffer 0
    c0 = cyc;
    req_q.push_back('{c0 + 1, 16'hFFFC, 1'b0});
    req_q.push_back('{c0 + 5, 16'hFFFE, 1'b0});
    req_q.push_back('{c0 + 9, 16'h0000, 1'b0});
    done_q.push_back(c0 + 12);
    start_line(16'hFFFC, 7'd3, 1'b0);
    tick(14);
    drained("s2_drained");

    // Two words, never answered: each waits 64 request cycles, the second
    // times out in cycle 129 and done follows in cycle 130
    resp_en = 1'b0;
    c0 = cyc;
    req_q.push_back('{c0 + 1, 16'h1000, 1'b1});
    req_q.push_back('{c0 + 66, 16'h1002, 1'b1});
    done_q.push_back(c0 + 130);
    start_line(16'h1000, 7'd2, 1'b1);
    tick(133);
    drained("s3_drained");
    chk("s3_err_set", 32'(terr), 32'd1);
    do_swap();
    read_check(5'd0, 32'h0);
    read_check(5'd1, 32'h0);
    read_check(5'd2, mkdata(16'h0000));
    tick(1);

    // Restart while a request is outstanding; the stale answer is discarded
    c0 = cyc;
    req_q.push_back('{c0 + 1, 16'h3000, 1'b0});
    start_line(16'h3000, 7'd2, 1'b0);
    req_q.push_back('{c0 + 8, 16'h4000, 1'b1});
    done_q.push_back(c0 + 11);
    man_q.push_back('{c0 + 7, 32'hDEADBEEF});
    man_q.push_back('{c0 + 10, mkdata(16'h4000)});
    tick(1);
    start_line(16'h4000, 7'd1, 1'b1);
    tick(12);
    drained("s4_drained");
    chk("s4_man_used", 32'(man_q.size()), 32'd0);
    do_swap();
    read_check(5'd0, mkdata(16'h4000));
    read_check(5'd1, mkdata(16'h2002));
    idx = 5'd0;
    tick(1);

    // Two swaps during a fetch collapse into one toggle in the done cycle
    resp_en = 1'b1;
    c0 = cyc;
    req_q.push_back('{c0 + 1, 16'h5000, 1'b0});
    req_q.push_back('{c0 + 5, 16'h5002, 1'b0});
    done_q.push_back(c0 + 8);
    rdat_q.push_back('{c0 + 8, mkdata(16'h4000)});
    rdat_q.push_back('{c0 + 9, mkdata(16'h5000)});
    rdat_q.push_back('{c0 + 10, mkdata(16'h5000)});
    rdat_q.push_back('{c0 + 11, mkdata(16'h5000)});
    start_line(16'h5000, 7'd2, 1'b0);
    tick(1);
    do_swap();
    tick(1);
    do_swap();
    tick(10);
    drained("s5_drained");

    // Oversized request clamps to 32 words
    c0 = cyc;
    for (int i = 0; i < 32; i++)
      req_q.push_back('{c0 + 1 + 4 * i, 16'(32'h6000 + 32'(2 * i)), 1'b1});
    done_q.push_back(c0 + 128);
    start_line(16'h6000, 7'd100, 1'b1);
    tick(131);
    drained("s6_drained");

    // Zero-length line: done next cycle, no request
    c0 = cyc;
    done_q.push_back(c0 + 1);
    start_line(16'h7000, 7'd0, 1'b0);
    tick(3);
    drained("s7_drained");
    chk("zero_not_busy", 32'(busy), 32'd0);

    // Reset mid-fetch drops the line silently and clears the error flag
    resp_en = 1'b0;
    c0 = cyc;
    req_q.push_back('{c0 + 1, 16'h8000, 1'b1});
    start_line(16'h8000, 7'd2, 1'b1);
    tick(2);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(terr), 32'd0);
    chk("mid_rst_rd", 32'(video_rd), 32'd0);
    tick(6);
    chk("post_rst_idle", 32'(busy), 32'd0);
    drained("s8_drained");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
